reg_read_stage: RTL and testbench
=================================

// Module: reg_read_stage
// PURPOSE
//  Register-read stage directly downstream of the scheduler. Takes the packet fired by select via
//  scheduler_reg_read_if, reads source operands from the physical register file held inside this
//  block, and forwards same-cycle writeback results. Presents a registered operand packet to execute
//  one cycle after fire. Owns the physical register file write ports driven by writeback.
// PARAMETERS
//  NUM_PREGS  64  physical registers; preg 0 is hardwired zero
//  XLEN       32  data width
//  NUM_WB     2   writeback write ports
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  asynchronous, active-low reset
//  reg_read_if    in   modport .reg_read  sched_pkt (disp_packet_t), fire_valid
//  flush          in   1                  squash the in-flight and arriving op
//  wb_valid       in   NUM_WB             writeback port valid
//  wb_preg        in   NUM_WB*PREG_W      writeback destination preg
//  wb_data        in   NUM_WB*XLEN        writeback data
//  ex_valid       out  1                  operand packet valid to execute
//  ex_pkt         out  rr_packet_t        sched_pkt fields plus rs1_val and rs2_val
// BEHAVIOUR
//  - Reset (rst==0): ex_valid=0 and ex_pkt='0 immediately (async). All pregs = 0.
//  - Latency: fire_valid at edge N leads to ex_valid=1 after edge N+1. No backpressure in either
//    direction; execute accepts every cycle. One op accepted per cycle; back-to-back fires allowed.
//  - Read: combinational index of the array by sched_pkt.prs1/prs2 in the fire cycle; result latched
//    into the output register. rsX_val = 0 when uses_rsX==0 or prsX==0.
//  - Bypass: if wb_valid[i] and wb_preg[i]==prsX in the fire cycle, rsX_val = wb_data[i]
//    (write-before-read). If several ports match, the highest index wins.
//  - Write: on posedge, wb_valid[i] writes wb_data[i] to wb_preg[i]. Writes to preg 0 are dropped.
//    If ports collide on the same preg, the highest index wins; a simulation assertion flags it.
//  - Flush: flush==1 at edge E gives ex_valid=0 after E, including an op firing in that same cycle.
//    Register file writes are unaffected by flush.
//  - No fire, no flush: ex_valid goes to 0 next cycle. ex_pkt holds its last value (don't-care).
//  - Reset mid-operation: in-flight op lost; the scheduler is reset in the same domain.
//  - X checks: assert that fire_valid and wb_valid are never X out of reset.
// STRUCTURE
//  CORE_PKG gains:
//   - PREG_W = $clog2(NUM_PREGS)
//   - disp_packet_t fields prs1, prs2, prd, uses_rs1, uses_rs2 (if absent)
//   - rr_packet_t = disp_packet_t + rs1_val + rs2_val
//  Sub-module phys_regfile: NUM_WB write ports, 2 async read ports, zero reg, collision priority.
//  Bypass mux and output register stay in reg_read_stage.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles -> ex_valid=0; fire reading prs1=9 -> rs1_val=0.
//  2 Write then read: wb preg5=0xDEADBEEF at N, fire prs1=5 at N+1
//    -> ex_valid=1 and rs1_val=0xDEADBEEF after N+2.
//  3 Same-cycle bypass: wb port1 preg7=0x1234 and fire prs2=7 in the same cycle
//    -> rs2_val=0x1234 next cycle.
//  4 Zero reg and collision: wb preg0=0xFFFFFFFF, then fire prs1=0 -> rs1_val=0.
//    wb0 and wb1 both to preg3 (0xA, 0xB) -> later read of preg3 = 0xB; assertion fires.
//  5 Flush: 4 back-to-back fires with flush on the 3rd -> ex_valid pattern 1,1,0,1.
//  6 Async reset mid-stream: drop rst between edges while ex_valid=1
//    -> ex_valid=0 before the next edge; regfile reads 0.

Source files
------------

// File: rtl/reg_read_stage_pkg.sv
// reg_read_stage_pkg: shared sizes and packet types for the register-read stage
package reg_read_stage_pkg;
  localparam int NUM_PREGS = 64;
  localparam int XLEN = 32;
  localparam int NUM_WB = 2;
  localparam int PREG_W = $clog2(NUM_PREGS);
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    logic uses_rs1;
    logic uses_rs2;
  } disp_packet_t;
  typedef struct packed {
    disp_packet_t disp;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
  } rr_packet_t;
endpackage

// File: rtl/reg_read_stage_if.sv
// reg_read_stage_if: scheduler-to-register-read fire handshake
interface reg_read_stage_if;
  import reg_read_stage_pkg::*;
  disp_packet_t sched_pkt;
  logic fire_valid;
  modport sched (output sched_pkt, fire_valid);
  modport reg_read (input sched_pkt, fire_valid);
endinterface

// File: rtl/reg_read_stage_phys_regfile.sv
// reg_read_stage_phys_regfile: multi-write, dual async-read physical register file with zero reg
module reg_read_stage_phys_regfile
  import reg_read_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_preg,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  input  preg_t                    rd_addr1,
  input  preg_t                    rd_addr2,
  output logic [XLEN-1:0]          rd_data1,
  output logic [XLEN-1:0]          rd_data2
);
  logic [XLEN-1:0] regs [NUM_PREGS];
  logic collide;
  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
  // ports applied in ascending order so the highest index wins; preg 0 is never written
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NUM_PREGS; i++) regs[i] <= '0;
    else
      for (int w = 0; w < NUM_WB; w++)
        if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] != '0)
          regs[wb_preg[w*PREG_W +: PREG_W]] <= wb_data[w*XLEN +: XLEN];
  // detect two live ports targeting the same non-zero preg
  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NUM_WB; i++)
      for (int j = i + 1; j < NUM_WB; j++)
        if (wb_valid[i] && wb_valid[j] && wb_preg[i*PREG_W +: PREG_W] == wb_preg[j*PREG_W +: PREG_W]
            && wb_preg[i*PREG_W +: PREG_W] != '0)
          collide = 1'b1;
  end
  a_no_collide: assert property (@(posedge clk) disable iff (!rst) !collide)
    else $warning("phys_regfile: write ports collide on one preg");
endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: operand read with writeback bypass, registered packet to execute
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  reg_read_stage_if.reg_read       reg_read_if,
  input  logic                     flush,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PREG_W-1:0] wb_preg,
  input  logic [NUM_WB*XLEN-1:0]   wb_data,
  output logic                     ex_valid,
  output rr_packet_t               ex_pkt
);
  disp_packet_t pkt;
  logic fire;
  logic [XLEN-1:0] rf1, rf2, rs1_val, rs2_val;
  assign pkt = reg_read_if.sched_pkt;
  assign fire = reg_read_if.fire_valid;
  reg_read_stage_phys_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_preg  (wb_preg),
    .wb_data  (wb_data),
    .rd_addr1 (pkt.prs1),
    .rd_addr2 (pkt.prs2),
    .rd_data1 (rf1),
    .rd_data2 (rf2)
  );
  // same-cycle writeback overrides the array, later ports win; unused or zero sources read 0
  always_comb begin
    rs1_val = rf1;
    rs2_val = rf2;
    for (int w = 0; w < NUM_WB; w++) begin
      if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] == pkt.prs1) rs1_val = wb_data[w*XLEN +: XLEN];
      if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] == pkt.prs2) rs2_val = wb_data[w*XLEN +: XLEN];
    end
    rs1_val = (!pkt.uses_rs1 || pkt.prs1 == '0) ? '0 : rs1_val;
    rs2_val = (!pkt.uses_rs2 || pkt.prs2 == '0) ? '0 : rs2_val;
  end
  // output register; flush only kills valid, the packet payload is don't-care then
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_pkt   <= '0;
    end else begin
      ex_valid <= fire && !flush;
      if (fire) ex_pkt <= '{disp: pkt, rs1_val: rs1_val, rs2_val: rs2_val};
    end
  a_fire_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(fire));
  a_wb_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(wb_valid));
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: directed and randomized checks against a cycle-level reference model
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;
  logic clk, rst, flush, ex_valid;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*PREG_W-1:0] wb_preg;
  logic [NUM_WB*XLEN-1:0] wb_data;
  rr_packet_t ex_pkt;
  reg_read_stage_if rif();
  reg_read_stage dut (
    .clk         (clk),
    .rst         (rst),
    .reg_read_if (rif),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_preg     (wb_preg),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_pkt      (ex_pkt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [XLEN-1:0] mrf [NUM_PREGS];
  logic exp_valid;
  rr_packet_t exp_pkt;

  function automatic logic [XLEN-1:0] model_read(preg_t p, logic u);
    logic [XLEN-1:0] r;
    if (!u || p == 0) return '0;
    r = mrf[p];
    for (int w = 0; w < NUM_WB; w++)
      if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] == p) r = wb_data[w*XLEN +: XLEN];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_PREGS; i++) mrf[i] = '0;
    exp_valid = 1'b0;
    exp_pkt = '0;
  endtask

  task automatic idle();
    rif.fire_valid = 1'b0;
    rif.sched_pkt = '0;
    flush = 1'b0;
    wb_valid = '0;
    wb_preg = '0;
    wb_data = '0;
  endtask

  task automatic set_wb(int port, logic [PREG_W-1:0] p, logic [XLEN-1:0] d);
    wb_valid[port] = 1'b1;
    wb_preg[port*PREG_W +: PREG_W] = p;
    wb_data[port*XLEN +: XLEN] = d;
  endtask

  task automatic fire(preg_t p1, preg_t p2, preg_t pd, logic u1, logic u2);
    rif.fire_valid = 1'b1;
    rif.sched_pkt = '{prs1: p1, prs2: p2, prd: pd, uses_rs1: u1, uses_rs2: u2};
  endtask

  // predict the edge from current inputs, advance one clock, land 1 time unit after it
  task automatic tick();
    logic nv;
    rr_packet_t np;
    nv = rif.fire_valid && !flush;
    np = exp_pkt;
    if (rif.fire_valid)
      np = '{disp: rif.sched_pkt,
             rs1_val: model_read(rif.sched_pkt.prs1, rif.sched_pkt.uses_rs1),
             rs2_val: model_read(rif.sched_pkt.prs2, rif.sched_pkt.uses_rs2)};
    @(posedge clk);
    for (int w = 0; w < NUM_WB; w++)
      if (wb_valid[w] && wb_preg[w*PREG_W +: PREG_W] != 0)
        mrf[wb_preg[w*PREG_W +: PREG_W]] = wb_data[w*XLEN +: XLEN];
    #1;
    exp_valid = nv;
    exp_pkt = np;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    n_checks++;
    if (ex_pkt !== '0) begin n_fail++; $display("FAIL reset_pkt got %h want 0", ex_pkt); end
    rst = 1'b1;
    fire(9, 0, 1, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pkt.rs1_val !== 32'h0)
      begin n_fail++; $display("FAIL reset_read9 got v=%b rs1=%h want v=1 rs1=0", ex_valid, ex_pkt.rs1_val); end
  endtask

  task automatic test_write_read();
    set_wb(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    fire(5, 0, 2, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pkt.rs1_val !== 32'hDEADBEEF)
      begin n_fail++; $display("FAIL write_read got v=%b rs1=%h want v=1 rs1=deadbeef", ex_valid, ex_pkt.rs1_val); end
    n_checks++;
    if (ex_pkt !== exp_pkt) begin n_fail++; $display("FAIL write_read_pkt got %h want %h", ex_pkt, exp_pkt); end
  endtask

  task automatic test_bypass();
    set_wb(1, 7, 32'h1234);
    fire(0, 7, 3, 1'b0, 1'b1);
    tick();
    idle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pkt.rs2_val !== 32'h1234)
      begin n_fail++; $display("FAIL bypass got v=%b rs2=%h want v=1 rs2=1234", ex_valid, ex_pkt.rs2_val); end
    set_wb(0, 8, 32'h1);
    set_wb(1, 8, 32'h2);
    fire(8, 8, 4, 1'b1, 1'b1);
    tick();
    idle();
    n_checks++;
    if (ex_pkt.rs1_val !== 32'h2 || ex_pkt.rs2_val !== 32'h2)
      begin n_fail++; $display("FAIL bypass_prio got rs1=%h rs2=%h want 2 2", ex_pkt.rs1_val, ex_pkt.rs2_val); end
  endtask

  task automatic test_zero_collision();
    set_wb(0, 0, 32'hFFFFFFFF);
    tick();
    idle();
    fire(0, 5, 1, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (ex_pkt.rs1_val !== 32'h0 || ex_pkt.rs2_val !== 32'h0)
      begin n_fail++; $display("FAIL zero_reg got rs1=%h rs2=%h want 0 0", ex_pkt.rs1_val, ex_pkt.rs2_val); end
    set_wb(0, 3, 32'hA);
    set_wb(1, 3, 32'hB);
    tick();
    idle();
    fire(3, 3, 1, 1'b1, 1'b1);
    tick();
    idle();
    n_checks++;
    if (ex_pkt.rs1_val !== 32'hB || ex_pkt.rs2_val !== 32'hB)
      begin n_fail++; $display("FAIL collision got rs1=%h rs2=%h want b b", ex_pkt.rs1_val, ex_pkt.rs2_val); end
  endtask

  task automatic test_flush();
    logic [3:0] pat;
    pat = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      fire(preg_t'(5 + i), 7, preg_t'(i), 1'b1, 1'b1);
      flush = (i == 2);
      tick();
      n_checks++;
      if (ex_valid !== pat[i]) begin n_fail++; $display("FAIL flush_%0d got v=%b want %b", i, ex_valid, pat[i]); end
      n_checks++;
      if (ex_valid && ex_pkt !== exp_pkt) begin n_fail++; $display("FAIL flush_pkt_%0d got %h want %h", i, ex_pkt, exp_pkt); end
    end
    idle();
    tick();
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drop got v=%b want 0", ex_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int w = 0; w < NUM_WB; w++)
        if ($urandom_range(0, 1) == 1) set_wb(w, preg_t'($urandom_range(0, 15)), $urandom);
      if (wb_valid == 2'b11 && wb_preg[PREG_W-1:0] == wb_preg[2*PREG_W-1:PREG_W]) wb_valid[1] = 1'b0;
      if ($urandom_range(0, 3) != 0)
        fire(preg_t'($urandom_range(0, 15)), preg_t'($urandom_range(0, 15)), preg_t'($urandom),
             1'($urandom), 1'($urandom));
      flush = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (ex_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid_%0d got %b want %b", c, ex_valid, exp_valid); end
      if (exp_valid) begin
        n_checks++;
        if (ex_pkt !== exp_pkt) begin n_fail++; $display("FAIL rand_pkt_%0d got %h want %h", c, ex_pkt, exp_pkt); end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    set_wb(0, 12, 32'hCAFE0001);
    tick();
    idle();
    fire(12, 0, 1, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pkt.rs1_val !== 32'hCAFE0001)
      begin n_fail++; $display("FAIL pre_reset got v=%b rs1=%h want v=1 rs1=cafe0001", ex_valid, ex_pkt.rs1_val); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (ex_valid !== 1'b0 || ex_pkt !== '0)
      begin n_fail++; $display("FAIL async_reset got v=%b pkt=%h want 0 0", ex_valid, ex_pkt); end
    @(posedge clk);
    #1 rst = 1'b1;
    fire(12, 0, 1, 1'b1, 1'b0);
    tick();
    idle();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pkt.rs1_val !== 32'h0)
      begin n_fail++; $display("FAIL post_reset_read got v=%b rs1=%h want v=1 rs1=0", ex_valid, ex_pkt.rs1_val); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_collision();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
